serial_add_sub: RTL

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

---
 rtl/serial_add_sub.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first.
// Operands are latched on start; results and flags hold until the next completion.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryBorrow,
  output logic             Overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               mode_q, mode_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-2:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cb_q, cb_d;
  logic               ov_q, ov_d;
  logic               done_q, done_d;

  // One-bit add/subtract cell on the current LSBs of the operand shifters
  logic             a_bit, b_bit, sum_bit, c_next, ov_bit, last_bit;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    a_bit    = a_q[0];
    b_bit    = b_q[0];
    sum_bit  = a_bit ^ b_bit ^ c_q;
    if (mode_q) begin
      c_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & c_q);
      ov_bit = (a_bit != b_bit) && (sum_bit != a_bit);
    end else begin
      c_next = (a_bit & b_bit) | (a_bit & c_q) | (b_bit & c_q);
      ov_bit = c_q ^ c_next;
    end
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH shifts the result is in normal order
    shifted  = {sum_bit, sr_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      sr_q     <= '0;
      result_q <= '0;
      cb_q     <= 1'b0;
      ov_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      result_q <= result_d;
      cb_q     <= cb_d;
      ov_q     <= ov_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    result_d = result_q;
    cb_d     = cb_q;
    ov_d     = ov_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          mode_d  = Mode;
          c_d     = 1'b0;
          cnt_d   = '0;
          sr_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_next;
        cnt_d = cnt_q + CNT_W'(1);
        sr_d  = shifted[WIDTH-1:1];
        if (last_bit) begin
          state_d  = S_DONE;
          result_d = shifted;
          cb_d     = c_next;
          ov_d     = ov_bit;
          done_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign Result      = result_q;
  assign CarryBorrow = cb_q;
  assign Overflow    = ov_q;

endmodule
